// File: rtl/data_sram_resp_pkg.sv
// Shared types for the data-side SRAM responder: FSM states, access sizes,
// queued request layout and the byte-lane enable decode.
package data_sram_resp_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACC,
        S_RESP
    } state_e;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    // Size 3 is not a legal access width; it decodes to no lanes.
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            SIZE_B:  be = 4'b0001 << addr_lo;
            SIZE_H:  be = addr_lo[1] ? 4'b1100 : 4'b0011;
            SIZE_W:  be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/data_sram_resp_req_fifo.sv
// Two-entry in-order request queue with full/empty flags.
module req_fifo
    import data_sram_resp_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  req_t push_data,
    input  logic pop,
    output req_t head,
    output logic full,
    output logic empty
);

    req_t       mem_q [2];
    req_t       mem_d [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       push_ok, pop_ok;

    assign full  = (count_q == 2'd2);
    assign empty = (count_q == 2'd0);
    assign head  = mem_q[rd_ptr_q];

    // A push while full is ignored even if a pop frees a slot this cycle.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/data_sram_resp.sv
// Data-port SRAM responder: queues up to two requests, optionally waits LAT
// cycles, performs one SRAM access and returns a one-cycle completion pulse.
//
// state  | meaning
// IDLE   | waiting for a queued request
// WAIT   | counting down extra latency (cnt down to 0)
// ACC    | SRAM strobe for the queue head
// RESP   | completion pulse, read data returned, head popped
module data_sram_resp
    import data_sram_resp_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int LAT    = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [31:0]       data_addr,
    input  logic [31:0]       data_wdata,
    output logic              data_addr_ok,
    output logic [31:0]       data_rdata,
    output logic              data_data_ok,
    output logic              ram_en,
    output logic [3:0]        ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam logic [3:0] CNT_INIT = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       push, pop, full, empty;
    req_t       push_data, head;
    logic       unused_addr_bits;

    assign data_addr_ok     = ~reset & ~full;
    assign push             = data_req & data_addr_ok;
    assign push_data        = '{data_wr, data_size, data_addr, data_wdata};
    assign unused_addr_bits = ^{head.addr[31:ADDR_W+2]};

    req_fifo u_req_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pop          = 1'b0;
        ram_en       = 1'b0;
        ram_wen      = 4'b0000;
        ram_addr     = head.addr[ADDR_W+1:2];
        ram_wdata    = head.wdata;
        data_data_ok = 1'b0;
        data_rdata   = 32'h0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    if (LAT > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = S_ACC;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_ACC;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_ACC: begin
                ram_en  = 1'b1;
                ram_wen = head.wr ? byte_en(head.size, head.addr[1:0]) : 4'b0000;
                state_d = S_RESP;
            end
            S_RESP: begin
                data_data_ok = 1'b1;
                data_rdata   = head.wr ? 32'h0 : ram_rdata;
                pop          = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Outputs stay quiet for the whole reset cycle, even before the state register clears.
        if (reset) begin
            pop          = 1'b0;
            ram_en       = 1'b0;
            ram_wen      = 4'b0000;
            data_data_ok = 1'b0;
            data_rdata   = 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed bench for data_sram_resp: one LAT=0 instance and one LAT=3 instance,
// each backed by a simple byte-writable synchronous SRAM model.
module tb_data_sram_resp;

    logic clk = 1'b0;
    logic reset;

    logic        req0, wr0;
    logic [1:0]  size0;
    logic [31:0] addr0, wdata0;
    logic        addr_ok0, data_ok0, ram_en0;
    logic [31:0] rdata0, ram_wdata0, ram_rdata0;
    logic [3:0]  ram_wen0;
    logic [15:0] ram_addr0;

    logic        req3, wr3;
    logic [1:0]  size3;
    logic [31:0] addr3, wdata3;
    logic        addr_ok3, data_ok3, ram_en3;
    logic [31:0] rdata3, ram_wdata3, ram_rdata3;
    logic [3:0]  ram_wen3;
    logic [15:0] ram_addr3;

    logic [31:0] mem0 [0:65535];
    logic [31:0] mem3 [0:65535];

    int n_cmp = 0;
    int n_err = 0;

    logic [1:0]  be_size  [7] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd0, 2'd3, 2'd2};
    logic [31:0] be_addr  [7] = '{32'h13, 32'h12, 32'h11, 32'h20, 32'h21, 32'h14, 32'h18};
    logic [31:0] be_wdata [7] = '{32'hAB000000, 32'h12340000, 32'h00005678, 32'h11223344,
                                  32'h0000CC00, 32'hFFFFFFFF, 32'hCAFEF00D};
    logic [3:0]  be_wen   [7] = '{4'b1000, 4'b1100, 4'b0011, 4'b1111, 4'b0010, 4'b0000, 4'b1111};

    logic        b2b_aok [11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        b2b_dok [11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] b2b_rd  [11] = '{32'h0, 32'h0, 32'h0, 32'h12345678, 32'h0, 32'h0, 32'h1122CC44,
                                  32'h0, 32'h0, 32'hCAFEF00D, 32'h0};

    always #5 clk = ~clk;

    data_sram_resp #(.ADDR_W(16), .LAT(0)) dut0 (
        .clk(clk), .reset(reset),
        .data_req(req0), .data_wr(wr0), .data_size(size0), .data_addr(addr0), .data_wdata(wdata0),
        .data_addr_ok(addr_ok0), .data_rdata(rdata0), .data_data_ok(data_ok0),
        .ram_en(ram_en0), .ram_wen(ram_wen0), .ram_addr(ram_addr0), .ram_wdata(ram_wdata0),
        .ram_rdata(ram_rdata0)
    );

    data_sram_resp #(.ADDR_W(16), .LAT(3)) dut3 (
        .clk(clk), .reset(reset),
        .data_req(req3), .data_wr(wr3), .data_size(size3), .data_addr(addr3), .data_wdata(wdata3),
        .data_addr_ok(addr_ok3), .data_rdata(rdata3), .data_data_ok(data_ok3),
        .ram_en(ram_en3), .ram_wen(ram_wen3), .ram_addr(ram_addr3), .ram_wdata(ram_wdata3),
        .ram_rdata(ram_rdata3)
    );

    always @(posedge clk) begin
        if (ram_en0) begin
            for (int b = 0; b < 4; b++)
                if (ram_wen0[b]) mem0[ram_addr0][8*b +: 8] <= ram_wdata0[8*b +: 8];
            ram_rdata0 <= mem0[ram_addr0];
        end
    end

    always @(posedge clk) begin
        if (ram_en3) begin
            for (int b = 0; b < 4; b++)
                if (ram_wen3[b]) mem3[ram_addr3][8*b +: 8] <= ram_wdata3[8*b +: 8];
            ram_rdata3 <= mem3[ram_addr3];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        n_cmp++; if (addr_ok0 !== 1'b0) begin n_err++; $display("FAIL rst_addr_ok0 got %b exp 0", addr_ok0); end
        n_cmp++; if (data_ok0 !== 1'b0) begin n_err++; $display("FAIL rst_data_ok0 got %b exp 0", data_ok0); end
        n_cmp++; if (rdata0 !== 32'h0) begin n_err++; $display("FAIL rst_rdata0 got %h exp 0", rdata0); end
        n_cmp++; if (ram_en0 !== 1'b0) begin n_err++; $display("FAIL rst_ram_en0 got %b exp 0", ram_en0); end
        n_cmp++; if (ram_wen0 !== 4'b0) begin n_err++; $display("FAIL rst_ram_wen0 got %b exp 0", ram_wen0); end
        n_cmp++; if (addr_ok3 !== 1'b0) begin n_err++; $display("FAIL rst_addr_ok3 got %b exp 0", addr_ok3); end
        n_cmp++; if (data_ok3 !== 1'b0) begin n_err++; $display("FAIL rst_data_ok3 got %b exp 0", data_ok3); end
        reset = 1'b0;
        #1;
        n_cmp++; if (addr_ok0 !== 1'b1) begin n_err++; $display("FAIL rel_addr_ok0 got %b exp 1", addr_ok0); end
        n_cmp++; if (addr_ok3 !== 1'b1) begin n_err++; $display("FAIL rel_addr_ok3 got %b exp 1", addr_ok3); end
        step();
    endtask

    task automatic test_write_read();
        req0 = 1'b1; wr0 = 1'b1; size0 = 2'd2; addr0 = 32'h10; wdata0 = 32'hDEADBEEF;
        #1;
        n_cmp++; if (addr_ok0 !== 1'b1) begin n_err++; $display("FAIL wr_addr_ok got %b exp 1", addr_ok0); end
        step();
        req0 = 1'b0;
        n_cmp++; if (ram_en0 !== 1'b0) begin n_err++; $display("FAIL wr_ram_en_c1 got %b exp 0", ram_en0); end
        step();
        n_cmp++; if (ram_en0 !== 1'b1) begin n_err++; $display("FAIL wr_ram_en_c2 got %b exp 1", ram_en0); end
        n_cmp++; if (ram_wen0 !== 4'b1111) begin n_err++; $display("FAIL wr_ram_wen got %b exp 1111", ram_wen0); end
        n_cmp++; if (ram_addr0 !== 16'h0004) begin n_err++; $display("FAIL wr_ram_addr got %h exp 0004", ram_addr0); end
        n_cmp++; if (ram_wdata0 !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_ram_wdata got %h exp deadbeef", ram_wdata0); end
        n_cmp++; if (data_ok0 !== 1'b0) begin n_err++; $display("FAIL wr_data_ok_c2 got %b exp 0", data_ok0); end
        step();
        n_cmp++; if (data_ok0 !== 1'b1) begin n_err++; $display("FAIL wr_data_ok_c3 got %b exp 1", data_ok0); end
        n_cmp++; if (rdata0 !== 32'h0) begin n_err++; $display("FAIL wr_rdata got %h exp 0", rdata0); end
        n_cmp++; if (ram_en0 !== 1'b0) begin n_err++; $display("FAIL wr_ram_en_c3 got %b exp 0", ram_en0); end
        step();
        n_cmp++; if (data_ok0 !== 1'b0) begin n_err++; $display("FAIL wr_data_ok_c4 got %b exp 0", data_ok0); end
        req0 = 1'b1; wr0 = 1'b0; addr0 = 32'h10;
        #1;
        n_cmp++; if (addr_ok0 !== 1'b1) begin n_err++; $display("FAIL rd_addr_ok got %b exp 1", addr_ok0); end
        step();
        req0 = 1'b0;
        step();
        n_cmp++; if (ram_en0 !== 1'b1) begin n_err++; $display("FAIL rd_ram_en got %b exp 1", ram_en0); end
        n_cmp++; if (ram_wen0 !== 4'b0000) begin n_err++; $display("FAIL rd_ram_wen got %b exp 0000", ram_wen0); end
        step();
        n_cmp++; if (data_ok0 !== 1'b1) begin n_err++; $display("FAIL rd_data_ok got %b exp 1", data_ok0); end
        n_cmp++; if (rdata0 !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_rdata got %h exp deadbeef", rdata0); end
        step();
    endtask

    task automatic test_byte_enables();
        for (int i = 0; i < 7; i++) begin
            req0 = 1'b1; wr0 = 1'b1; size0 = be_size[i]; addr0 = be_addr[i]; wdata0 = be_wdata[i];
            #1;
            n_cmp++; if (addr_ok0 !== 1'b1) begin n_err++; $display("FAIL be%0d_addr_ok got %b exp 1", i, addr_ok0); end
            step();
            req0 = 1'b0;
            step();
            n_cmp++; if (ram_en0 !== 1'b1) begin n_err++; $display("FAIL be%0d_ram_en got %b exp 1", i, ram_en0); end
            n_cmp++; if (ram_wen0 !== be_wen[i]) begin n_err++; $display("FAIL be%0d_ram_wen got %b exp %b", i, ram_wen0, be_wen[i]); end
            n_cmp++; if (ram_addr0 !== be_addr[i][17:2]) begin n_err++; $display("FAIL be%0d_ram_addr got %h exp %h", i, ram_addr0, be_addr[i][17:2]); end
            step();
            n_cmp++; if (data_ok0 !== 1'b1) begin n_err++; $display("FAIL be%0d_data_ok got %b exp 1", i, data_ok0); end
            step();
        end
        req0 = 1'b1; wr0 = 1'b0; size0 = 2'd2; addr0 = 32'h10;
        step();
        req0 = 1'b0;
        step();
        step();
        n_cmp++; if (data_ok0 !== 1'b1) begin n_err++; $display("FAIL be_merge_data_ok got %b exp 1", data_ok0); end
        n_cmp++; if (rdata0 !== 32'h12345678) begin n_err++; $display("FAIL be_merge_rdata got %h exp 12345678", rdata0); end
        step();
    endtask

    task automatic test_back_to_back();
        wr0 = 1'b0; size0 = 2'd2;
        for (int c = 0; c < 11; c++) begin
            req0  = (c <= 4);
            addr0 = (c == 0) ? 32'h10 : (c == 1) ? 32'h20 : 32'h18;
            #1;
            n_cmp++; if (addr_ok0 !== b2b_aok[c]) begin n_err++; $display("FAIL b2b_addr_ok c%0d got %b exp %b", c, addr_ok0, b2b_aok[c]); end
            n_cmp++; if (data_ok0 !== b2b_dok[c]) begin n_err++; $display("FAIL b2b_data_ok c%0d got %b exp %b", c, data_ok0, b2b_dok[c]); end
            n_cmp++; if (rdata0 !== b2b_rd[c]) begin n_err++; $display("FAIL b2b_rdata c%0d got %h exp %h", c, rdata0, b2b_rd[c]); end
            step();
        end
        req0 = 1'b0;
    endtask

    task automatic test_latency();
        for (int t = 0; t < 2; t++) begin
            for (int c = 0; c < 8; c++) begin
                req3 = (c == 0); wr3 = (t == 0); size3 = 2'd2; addr3 = 32'h10; wdata3 = 32'h5A5AA5A5;
                #1;
                if (c == 0) begin
                    n_cmp++; if (addr_ok3 !== 1'b1) begin n_err++; $display("FAIL lat_addr_ok t%0d got %b exp 1", t, addr_ok3); end
                end
                n_cmp++; if (data_ok3 !== (c == 6)) begin n_err++; $display("FAIL lat_data_ok t%0d c%0d got %b exp %b", t, c, data_ok3, (c == 6)); end
                n_cmp++; if (ram_en3 !== (c == 5)) begin n_err++; $display("FAIL lat_ram_en t%0d c%0d got %b exp %b", t, c, ram_en3, (c == 5)); end
                if (t == 1 && c == 6) begin
                    n_cmp++; if (rdata3 !== 32'h5A5AA5A5) begin n_err++; $display("FAIL lat_rdata got %h exp 5a5aa5a5", rdata3); end
                end
                step();
            end
        end
        req3 = 1'b0;
    endtask

    task automatic test_reset_mid();
        req3 = 1'b1; wr3 = 1'b0; size3 = 2'd2; addr3 = 32'h10;
        #1;
        n_cmp++; if (addr_ok3 !== 1'b1) begin n_err++; $display("FAIL rm_addr_ok_c0 got %b exp 1", addr_ok3); end
        step();
        addr3 = 32'h14;
        #1;
        n_cmp++; if (addr_ok3 !== 1'b1) begin n_err++; $display("FAIL rm_addr_ok_c1 got %b exp 1", addr_ok3); end
        step();
        req3  = 1'b0;
        reset = 1'b1;
        #1;
        n_cmp++; if (addr_ok3 !== 1'b0) begin n_err++; $display("FAIL rm_addr_ok_c2 got %b exp 0", addr_ok3); end
        n_cmp++; if (data_ok3 !== 1'b0) begin n_err++; $display("FAIL rm_data_ok_c2 got %b exp 0", data_ok3); end
        step();
        n_cmp++; if (addr_ok3 !== 1'b0) begin n_err++; $display("FAIL rm_addr_ok_c3 got %b exp 0", addr_ok3); end
        n_cmp++; if (ram_en3 !== 1'b0) begin n_err++; $display("FAIL rm_ram_en_c3 got %b exp 0", ram_en3); end
        step();
        reset = 1'b0;
        #1;
        n_cmp++; if (addr_ok3 !== 1'b1) begin n_err++; $display("FAIL rm_addr_ok_rel got %b exp 1", addr_ok3); end
        for (int c = 0; c < 12; c++) begin
            n_cmp++; if (data_ok3 !== 1'b0) begin n_err++; $display("FAIL rm_data_ok_after c%0d got %b exp 0", c, data_ok3); end
            n_cmp++; if (ram_en3 !== 1'b0) begin n_err++; $display("FAIL rm_ram_en_after c%0d got %b exp 0", c, ram_en3); end
            step();
        end
    endtask

    initial begin
        reset = 1'b1;
        req0 = 1'b0; wr0 = 1'b0; size0 = 2'd0; addr0 = 32'h0; wdata0 = 32'h0;
        req3 = 1'b0; wr3 = 1'b0; size3 = 2'd0; addr3 = 32'h0; wdata3 = 32'h0;
        test_reset();
        test_write_read();
        test_byte_enables();
        test_back_to_back();
        test_latency();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
